// File: rtl/uart_pwm_pkg.sv
// Shared definitions for the UART-to-PWM datapath: sync marker, frame layout,
// parser state encoding and the frame checksum.
package uart_pwm_pkg;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN         = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_SYNC,
    ST_GOT_CH,
    ST_GOT_DHI,
    ST_GOT_DLO
  } parser_state_t;

  function automatic logic [7:0] cmd_checksum(input logic [7:0] ch,
                                              input logic [7:0] dhi,
                                              input logic [7:0] dlo);
    return ch ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap timer: counts cycles while enabled, restarts on clear and
// flags a single-cycle expiry when the count reaches TIMEOUT_CYC.
module cmd_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 53999
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // A byte arriving on the compare cycle keeps the frame alive.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CH/DHI/DLO/CHK frames from the UART receiver and writes
// checked values into the per-channel PWM duty register bank.
module uart_cmd_parser
  import uart_pwm_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DUTY_BITS  = 16,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_break,
  output logic [NUM_CH*DUTY_BITS-1:0]   o_duty,
  output logic [NUM_CH-1:0]             o_duty_update,
  output logic                          o_frame_ok,
  output logic                          o_frame_err,
  output logic [7:0]                    o_err_count
);

  localparam int unsigned TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US - 1;
  localparam logic [16:0] DUTY_MAX    = 17'((32'd1 << DUTY_BITS) - 32'd1);
  localparam logic [7:0]  CH_LIMIT    = 8'(NUM_CH);

  parser_state_t state, state_next;
  logic [7:0]    ch_q, dhi_q, dlo_q;
  logic          commit, drop;
  logic          timer_expired;
  logic [15:0]   raw;
  logic [DUTY_BITS-1:0] duty_sat;
  logic [DUTY_BITS-1:0] duty_q [NUM_CH];

  cmd_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .clear    (i_rx_valid),
    .enable   (state != ST_IDLE),
    .expired  (timer_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    drop       = 1'b0;
    if (i_rx_valid) begin
      if (state != ST_IDLE && i_rx_break) begin
        drop       = 1'b1;
        state_next = ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (!i_rx_break && i_rx_data == SYNC_BYTE) state_next = ST_GOT_SYNC;
          end
          ST_GOT_SYNC: begin
            if (i_rx_data >= CH_LIMIT) begin
              drop       = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_GOT_CH;
            end
          end
          ST_GOT_CH:  state_next = ST_GOT_DHI;
          ST_GOT_DHI: state_next = ST_GOT_DLO;
          ST_GOT_DLO: begin
            if (cmd_checksum(ch_q, dhi_q, dlo_q) == i_rx_data) commit = 1'b1;
            else                                                drop   = 1'b1;
            state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (timer_expired) begin
      drop       = 1'b1;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      ch_q  <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
    end else if (i_rx_valid && !i_rx_break) begin
      case (state)
        ST_GOT_SYNC: ch_q  <= i_rx_data;
        ST_GOT_CH:   dhi_q <= i_rx_data;
        ST_GOT_DHI:  dlo_q <= i_rx_data;
        default: ;
      endcase
    end
  end

  // Out-of-range values clamp to full scale rather than wrapping.
  assign raw      = {dhi_q, dlo_q};
  assign duty_sat = ({1'b0, raw} > DUTY_MAX) ? '1 : raw[DUTY_BITS-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int unsigned k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
      o_duty_update <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (commit && ch_q == 8'(k)) duty_q[k] <= duty_sat;
        o_duty_update[k] <= commit && (ch_q == 8'(k));
      end
    end
  end

  always_comb begin
    o_duty = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) o_duty[k*DUTY_BITS +: DUTY_BITS] = duty_q[k];
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_frame_ok  <= commit;
      o_frame_err <= drop;
      if (drop && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a frame-level model checked every cycle against two
// instances (default, and 8-bit duty with a 100-cycle timeout), plus literal pins.
module tb_uart_cmd_parser;
  import uart_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  logic [63:0] duty_a;
  logic [3:0]  upd_a;
  logic        ok_a, err_a;
  logic [7:0]  cnt_a;
  logic [31:0] duty_b;
  logic [3:0]  upd_b;
  logic        ok_b, err_b;
  logic [7:0]  cnt_b;

  uart_cmd_parser #(
    .CLK_HZ(27_000_000), .NUM_CH(4), .DUTY_BITS(16), .TIMEOUT_US(2000), .SYNC_BYTE(8'hA5)
  ) dut_a (
    .i_clk(clk), .i_resetn(resetn), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_break(rx_break), .o_duty(duty_a), .o_duty_update(upd_a),
    .o_frame_ok(ok_a), .o_frame_err(err_a), .o_err_count(cnt_a)
  );

  uart_cmd_parser #(
    .CLK_HZ(1_000_000), .NUM_CH(4), .DUTY_BITS(8), .TIMEOUT_US(100), .SYNC_BYTE(8'hA5)
  ) dut_b (
    .i_clk(clk), .i_resetn(resetn), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_break(rx_break), .o_duty(duty_b), .o_duty_update(upd_b),
    .o_frame_ok(ok_b), .o_frame_err(err_b), .o_err_count(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes collected so far, idle cycles since the last byte.
  int unsigned m_to [2]  = '{53999, 99};
  int unsigned m_max[2]  = '{65535, 255};
  int          m_len[2]  = '{0, 0};
  logic [7:0]  m_fb [2][5];
  int unsigned m_gap[2]  = '{0, 0};
  int unsigned m_ch [2][4];
  logic [3:0]  m_upd[2];
  logic        m_ok [2];
  logic        m_err[2];
  int unsigned m_cnt[2]  = '{0, 0};
  int unsigned raw;

  task automatic model_drop(input int i);
    m_err[i] = 1'b1;
    if (m_cnt[i] < 255) m_cnt[i]++;
    m_len[i] = 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_upd[i] = 4'b0;
      m_ok[i]  = 1'b0;
      m_err[i] = 1'b0;
      if (!resetn) begin
        m_len[i] = 0;
        m_gap[i] = 0;
        m_cnt[i] = 0;
        for (int j = 0; j < 4; j++) m_ch[i][j] = 0;
      end else if (rx_valid) begin
        m_gap[i] = 0;
        if (m_len[i] == 0) begin
          if (!rx_break && rx_data == 8'hA5) begin
            m_fb[i][0] = rx_data;
            m_len[i]   = 1;
          end
        end else if (rx_break) begin
          model_drop(i);
        end else begin
          m_fb[i][m_len[i]] = rx_data;
          m_len[i]++;
          if (m_len[i] == 2 && rx_data >= 8'd4) begin
            model_drop(i);
          end else if (m_len[i] == FRAME_LEN) begin
            if ((m_fb[i][1] ^ m_fb[i][2] ^ m_fb[i][3]) == m_fb[i][4]) begin
              raw = {16'h0, m_fb[i][2], m_fb[i][3]};
              m_ch[i][m_fb[i][1]]  = (raw > m_max[i]) ? m_max[i] : raw;
              m_upd[i][m_fb[i][1]] = 1'b1;
              m_ok[i]              = 1'b1;
              m_len[i]             = 0;
            end else begin
              model_drop(i);
            end
          end
        end
      end else if (m_len[i] != 0) begin
        if (m_gap[i] == m_to[i]) model_drop(i);
        else                     m_gap[i]++;
      end
    end
  end

  logic        chk_en = 1'b0;
  logic [63:0] ea;
  logic [31:0] eb;
  int          err_seen_a = 0;
  int          err_seen_b = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      ea = '0;
      eb = '0;
      for (int j = 0; j < 4; j++) begin
        ea[j*16 +: 16] = m_ch[0][j][15:0];
        eb[j*8  +: 8]  = m_ch[1][j][7:0];
      end
      check("duty_a", duty_a, ea);
      check("upd_a",  upd_a,  m_upd[0]);
      check("ok_a",   ok_a,   m_ok[0]);
      check("err_a",  err_a,  m_err[0]);
      check("cnt_a",  cnt_a,  m_cnt[0][7:0]);
      check("duty_b", duty_b, eb);
      check("upd_b",  upd_b,  m_upd[1]);
      check("ok_b",   ok_b,   m_ok[1]);
      check("err_b",  err_b,  m_err[1]);
      check("cnt_b",  cnt_b,  m_cnt[1][7:0]);
      err_seen_a += int'(err_a);
      err_seen_b += int'(err_b);
    end
  end

  task automatic send(input logic [7:0] d, input logic brk);
    @(posedge clk);
    #1 rx_valid = 1'b1; rx_data = d; rx_break = brk;
    @(posedge clk);
    #1 rx_valid = 1'b0; rx_break = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send(b0, 1'b0); send(b1, 1'b0); send(b2, 1'b0); send(b3, 1'b0); send(b4, 1'b0);
  endtask

  task automatic burst(input logic [7:0] q[$]);
    @(posedge clk);
    foreach (q[k]) begin
      #1 rx_valid = 1'b1; rx_data = q[k]; rx_break = 1'b0;
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
  endtask

  int base_a, base_b;

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;
    check("rst_duty_a", duty_a, 64'h0);
    check("rst_duty_b", duty_b, 64'h0);
    check("rst_upd_a",  upd_a,  4'h0);
    check("rst_ok_a",   ok_a,   1'b0);
    check("rst_err_a",  err_a,  1'b0);
    check("rst_cnt_a",  cnt_a,  8'h00);

    send_frame(8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
    check("f1_ch2_a",   duty_a[47:32], 16'h1234);
    check("f1_upd_a",   upd_a, 4'b0100);
    check("f1_ok_a",    ok_a, 1'b1);
    check("f1_other_a", {duty_a[63:48], duty_a[31:0]}, 48'h0);
    check("f1_ch2_b",   duty_b[23:16], 8'hFF);
    @(posedge clk); #1;
    check("f1_ok_gone", ok_a, 1'b0);
    check("f1_upd_gone", upd_a, 4'b0000);

    send_frame(8'hA5, 8'h01, 8'h01, 8'h00, 8'h00);
    check("sat_ch1_b", duty_b[15:8], 8'hFF);
    check("sat_ch1_a", duty_a[31:16], 16'h0100);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7E);
    check("nosat_ch1_b", duty_b[15:8], 8'h7F);

    send_frame(8'hA5, 8'h00, 8'h11, 8'h22, 8'h00);
    check("badchk_err", err_a, 1'b1);
    check("badchk_cnt", cnt_a, 8'd1);
    check("badchk_ch0", duty_a[15:0], 16'h0000);
    send_frame(8'hA5, 8'h00, 8'h11, 8'h22, 8'h33);
    check("good_ok",  ok_a, 1'b1);
    check("good_ch0", duty_a[15:0], 16'h1122);

    send(8'hA5, 1'b0); send(8'h05, 1'b0);
    check("badch_err", err_a, 1'b1);
    check("badch_cnt", cnt_a, 8'd2);
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    check("ignored_cnt", cnt_a, 8'd2);
    send_frame(8'hA5, 8'h03, 8'h01, 8'h02, 8'h00);
    check("after_badch_ch3", duty_a[63:48], 16'h0102);

    send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h55, 1'b0); send(8'h00, 1'b1);
    check("brk_err", err_a, 1'b1);
    check("brk_cnt", cnt_a, 8'd3);
    send(8'h00, 1'b1);
    check("brk_idle_err", err_a, 1'b0);
    check("brk_idle_cnt", cnt_a, 8'd3);

    burst('{8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h05});
    check("b2b_ch3_a", duty_a[63:48], 16'hABCD);
    check("b2b_ch0_a", duty_a[15:0], 16'h0005);
    check("b2b_ch3_b", duty_b[31:24], 8'hFF);

    base_b = err_seen_b;
    send(8'hA5, 1'b0); send(8'h03, 1'b0);
    repeat (98) @(posedge clk);
    send(8'h00, 1'b0); send(8'h42, 1'b0); send(8'h41, 1'b0);
    check("keepalive_err_b", err_seen_b - base_b, 0);
    check("keepalive_ok_b",  ok_b, 1'b1);
    check("keepalive_ch3_b", duty_b[31:24], 8'h42);

    base_b = err_seen_b;
    send(8'hA5, 1'b0); send(8'h02, 1'b0);
    repeat (99) @(posedge clk);
    send(8'h00, 1'b0);
    repeat (3) @(posedge clk);
    check("late_err_b", err_seen_b - base_b, 1);

    send(8'hA5, 1'b0); send(8'h02, 1'b0);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_err",  err_a, 1'b0);
    check("midrst_duty", duty_a, 64'h0);
    check("midrst_cnt",  cnt_a, 8'h00);
    resetn = 1'b1;

    base_a = err_seen_a;
    base_b = err_seen_b;
    send(8'hA5, 1'b0); send(8'h03, 1'b0);
    repeat (54005) @(posedge clk);
    #1;
    check("timeout_err_a", err_seen_a - base_a, 1);
    check("timeout_err_b", err_seen_b - base_b, 1);
    check("timeout_cnt_a", cnt_a, 8'd1);

    for (int k = 0; k < 300; k++) begin
      send(8'hA5, 1'b0); send(8'h05, 1'b0);
    end
    check("sat_cnt_a", cnt_a, 8'hFF);
    check("sat_cnt_b", cnt_b, 8'hFF);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
